ultrasound_measurement_scheduler: RTL and testbench
===================================================

// Module: ultrasound_measurement_scheduler
// PURPOSE
//  Sequences the ultrasound location calculator for the main FPGA. Fires periodic or on-demand
//  measurements and supervises each one with a timeout/recovery path. Median-filters valid
//  distances and publishes {angle,distance} to the rover-tracking logic over a valid/ack handshake.
// PARAMETERS
//  PERIOD_CYCLES   2700000   cycles between measurement starts when enabled (10 Hz @ 27 MHz)
//  TIMEOUT_CYCLES  30000000  max cycles in WAIT_DONE before abort (> calculator worst case incl. power cycle)
//  RECOVER_CYCLES  16        cycles calc_reset is held high after a timeout
// PORTS
//  clock           in   1   system clock (27 MHz)
//  reset_n         in   1   synchronous, active-low reset
//  enable          in   1   level: run periodic measurements
//  request         in   1   one-cycle pulse: run a single measurement now
//  calc_done       in   1   calculator done pulse
//  calc_location   in   12  calculator result {angle[11:8], distance[7:0]}, valid with calc_done
//  calculate       out  1   one-cycle start pulse to calculator
//  calc_reset      out  1   active-high reset to calculator during recovery
//  location        out  12  filtered {angle, distance}
//  location_valid  out  1   location holds unconsumed data
//  location_ack    in   1   consumer accepts location (meaningful only while location_valid=1)
//  overrun         out  1   sticky: a publish replaced unacked data
//  fault_count     out  8   timeouts seen, saturates at 255
//  busy            out  1   1 in FIRE/WAIT_DONE/RECOVER/FILTER/PUBLISH
//  state           out  3   FSM state (debug)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): all outputs 0, state=IDLE, history empty, timers 0, pend=0.
//  States: IDLE=0 WAIT_PERIOD=1 FIRE=2 WAIT_DONE=3 RECOVER=4 FILTER=5 PUBLISH=6.
//  pend: set by request in any state except IDLE; cleared on entering FIRE.
//  IDLE: request or enable -> FIRE (first periodic shot is immediate).
//  FIRE: calculate=1 this cycle only; period timer and timeout timer cleared -> WAIT_DONE.
//  Period timer free-runs from FIRE, saturating at PERIOD_CYCLES-1.
//  WAIT_DONE: calc_done=1 -> capture calc_location, FILTER; else timeout timer reaches
//   TIMEOUT_CYCLES-1 -> RECOVER, fault_count+1 (sat 255). calc_done ignored in all other states.
//  RECOVER: calc_reset=1 for exactly RECOVER_CYCLES cycles, then -> NEXT. No publish.
//  FILTER: distance==0 -> no history update, no publish, -> NEXT. Else shift distance into
//   3-deep history, latch angle -> PUBLISH.
//  Filter output: 1 valid entry -> it; 2 -> smaller; 3 -> median. Angle = newest valid angle.
//  PUBLISH: location <= {angle, filtered}, location_valid <= 1 -> NEXT. If location_valid=1 and
//   location_ack=0 this cycle, overrun <= 1. Simultaneous ack+publish: valid stays 1, no overrun.
//  Latency: location_valid rises 2 edges after the edge that samples calc_done=1.
//  location_ack with location_valid=1 (not in PUBLISH): location_valid <= 0, overrun <= 0.
//  NEXT (resolved in same cycle): pend or request -> FIRE; else enable -> WAIT_PERIOD; else IDLE.
//  WAIT_PERIOD: enable=0 -> IDLE; request -> FIRE; period timer == PERIOD_CYCLES-1 -> FIRE
//   (immediate if measurement exceeded the period).
//  enable dropping mid-measurement: measurement completes and publishes, then IDLE.
//  History cleared only by reset; fault_count/overrun never wrap.
// TESTING
//  enable=1, calc_done 1000 cycles after each calculate, calc_location=0x312 -> calculate every
//   PERIOD_CYCLES cycles; location=0x312, valid 2 edges after done.
//  Distances 0x40,0x10,0x20 on three shots -> published distances 0x40, 0x10, 0x20 (median).
//  calc_done never asserted -> calc_reset high 16 cycles after TIMEOUT_CYCLES; fault_count=1; no valid.
//  Result with distance 0 -> no publish, history unchanged; next 0x30 publishes median incl. old entries.
//  Two publishes without ack -> overrun=1, location = second value; ack -> valid=0, overrun=0.
//  request during WAIT_DONE, enable=0 -> second calculate pulse directly after PUBLISH, then IDLE;
//   reset_n=0 mid WAIT_DONE -> all outputs 0 next edge.

Source files
------------

// File: rtl/ultrasound_measurement_scheduler.sv
// Sequences the ultrasound location calculator: periodic/on-demand shots, timeout recovery,
// 3-tap median filtering of distances and a valid/ack publish of {angle, distance}.
module ultrasound_measurement_scheduler #(
  parameter int PERIOD_CYCLES  = 2700000,
  parameter int TIMEOUT_CYCLES = 30000000,
  parameter int RECOVER_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        request,
  input  logic        calc_done,
  input  logic [11:0] calc_location,
  output logic        calculate,
  output logic        calc_reset,
  output logic [11:0] location,
  output logic        location_valid,
  input  logic        location_ack,
  output logic        overrun,
  output logic [7:0]  fault_count,
  output logic        busy,
  output logic [2:0]  state
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RECOVER_LAST = RW'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_PERIOD = 3'd1,
    S_FIRE        = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_RECOVER     = 3'd4,
    S_FILTER      = 3'd5,
    S_PUBLISH     = 3'd6
  } state_t;

  state_t          cur_st, nxt_st, after_st;
  logic [PW-1:0]   period_tmr;
  logic [TW-1:0]   timeout_tmr;
  logic [RW-1:0]   recover_tmr;
  logic            pend;
  logic [11:0]     cap_loc;
  logic [7:0]      hist0, hist1, hist2;
  logic [1:0]      hist_cnt;
  logic [3:0]      angle_q;
  logic [7:0]      filt;
  logic            cap_zero;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] median3(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    return max8(min8(a, b), min8(max8(a, b), c));
  endfunction

  assign cap_zero = (cap_loc[7:0] == 8'd0);

  // Filter output; history holds at least one entry whenever PUBLISH is reached
  always_comb begin
    filt = hist0;
    case (hist_cnt)
      2'd2:    filt = min8(hist0, hist1);
      2'd3:    filt = median3(hist0, hist1, hist2);
      default: filt = hist0;
    endcase
  end

  // Where a measurement goes once it has finished (published, dropped or recovered)
  always_comb begin
    if (pend || request) after_st = S_FIRE;
    else if (enable)     after_st = S_WAIT_PERIOD;
    else                 after_st = S_IDLE;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE:        if (request || enable) nxt_st = S_FIRE;
      S_WAIT_PERIOD: begin
        if (!enable)                        nxt_st = S_IDLE;
        else if (request)                   nxt_st = S_FIRE;
        else if (period_tmr == PERIOD_LAST) nxt_st = S_FIRE;
      end
      S_FIRE:        nxt_st = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (calc_done)                        nxt_st = S_FILTER;
        else if (timeout_tmr == TIMEOUT_LAST) nxt_st = S_RECOVER;
      end
      S_RECOVER:     if (recover_tmr == RECOVER_LAST) nxt_st = after_st;
      S_FILTER:      nxt_st = cap_zero ? after_st : S_PUBLISH;
      S_PUBLISH:     nxt_st = after_st;
      default:       nxt_st = S_IDLE;
    endcase
  end

  assign calculate  = (cur_st == S_FIRE);
  assign calc_reset = (cur_st == S_RECOVER);
  assign busy       = (cur_st != S_IDLE) && (cur_st != S_WAIT_PERIOD);
  assign state      = cur_st;

  // Control: state, timers, history occupancy and the published output
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_st         <= S_IDLE;
      pend           <= 1'b0;
      period_tmr     <= '0;
      timeout_tmr    <= '0;
      recover_tmr    <= '0;
      hist_cnt       <= 2'd0;
      location       <= 12'd0;
      location_valid <= 1'b0;
      overrun        <= 1'b0;
      fault_count    <= 8'd0;
    end else begin
      cur_st <= nxt_st;

      if (nxt_st == S_FIRE)                  pend <= 1'b0;
      else if (request && cur_st != S_IDLE)  pend <= 1'b1;

      // Cleared on the way into FIRE so the shot-to-shot spacing is exactly one period
      if (nxt_st == S_FIRE)              period_tmr <= '0;
      else if (period_tmr != PERIOD_LAST) period_tmr <= period_tmr + 1'b1;

      if (cur_st == S_WAIT_DONE) timeout_tmr <= timeout_tmr + 1'b1;
      else                       timeout_tmr <= '0;

      if (cur_st == S_RECOVER) recover_tmr <= recover_tmr + 1'b1;
      else                     recover_tmr <= '0;

      if (cur_st == S_WAIT_DONE && !calc_done && timeout_tmr == TIMEOUT_LAST &&
          fault_count != 8'hFF)
        fault_count <= fault_count + 8'd1;

      if (cur_st == S_FILTER && !cap_zero && hist_cnt != 2'd3)
        hist_cnt <= hist_cnt + 2'd1;

      if (cur_st == S_PUBLISH) begin
        location       <= {angle_q, filt};
        location_valid <= 1'b1;
        if (location_valid && !location_ack) overrun <= 1'b1;
      end else if (location_valid && location_ack) begin
        location_valid <= 1'b0;
        overrun        <= 1'b0;
      end
    end
  end

  // Data capture: calculator result, then distance history shift and angle latch
  always_ff @(posedge clock) begin
    if (cur_st == S_WAIT_DONE && calc_done) cap_loc <= calc_location;
    if (cur_st == S_FILTER && !cap_zero) begin
      hist2   <= hist1;
      hist1   <= hist0;
      hist0   <= cap_loc[7:0];
      angle_q <= cap_loc[11:8];
    end
  end

endmodule

// File: tb/tb_ultrasound_measurement_scheduler.sv
// Directed bench for ultrasound_measurement_scheduler with a simple calculator responder.
module tb_ultrasound_measurement_scheduler;

  localparam int P = 40;
  localparam int T = 50;
  localparam int R = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FIRE      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_FILTER    = 3'd5;
  localparam logic [2:0] ST_PUBLISH   = 3'd6;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        request;
  logic        calc_done;
  logic [11:0] calc_location;
  logic        calculate;
  logic        calc_reset;
  logic [11:0] location;
  logic        location_valid;
  logic        location_ack;
  logic        overrun;
  logic [7:0]  fault_count;
  logic        busy;
  logic [2:0]  state;

  int          compared = 0;
  int          mismatched = 0;
  logic        resp_en;
  int          resp_delay;
  logic [11:0] resp_loc;

  ultrasound_measurement_scheduler #(
    .PERIOD_CYCLES (P),
    .TIMEOUT_CYCLES(T),
    .RECOVER_CYCLES(R)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .request       (request),
    .calc_done     (calc_done),
    .calc_location (calc_location),
    .calculate     (calculate),
    .calc_reset    (calc_reset),
    .location      (location),
    .location_valid(location_valid),
    .location_ack  (location_ack),
    .overrun       (overrun),
    .fault_count   (fault_count),
    .busy          (busy),
    .state         (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Calculator model: answers each calculate pulse after resp_delay cycles
  initial begin
    calc_done = 1'b0;
    calc_location = 12'd0;
    forever begin
      @(posedge clock); #1;
      calc_done = 1'b0;
      if (calculate && resp_en) begin
        repeat (resp_delay) @(posedge clock);
        #1;
        calc_done = 1'b1;
        calc_location = resp_loc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; request = 1'b0; location_ack = 1'b0;
    resp_en = 1'b1; resp_delay = 5;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (state == s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic shot(input logic [11:0] loc, output logic [11:0] got, output bit ok);
    resp_loc = loc; request = 1'b1; tick(); request = 1'b0;
    wait_state(ST_PUBLISH, ok);
    tick();
    got = location;
  endtask

  task automatic ack();
    location_ack = 1'b1; tick(); location_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; request = 1'b1;
    tick(); tick(); tick();
    compared++; if (state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want 0", state); end
    compared++; if ({calculate, calc_reset, busy, location_valid, overrun} !== 5'b0) begin mismatched++; $display("FAIL reset_flags: got %b want 00000", {calculate, calc_reset, busy, location_valid, overrun}); end
    compared++; if ({location, fault_count} !== 20'h0) begin mismatched++; $display("FAIL reset_data: got %h want 00000", {location, fault_count}); end
    request = 1'b0; enable = 1'b0;
  endtask

  task automatic test_periodic();
    int fire0, fire1, nfire, vld_t;
    logic [11:0] got;
    bit ok;
    do_reset();
    fire0 = -1; fire1 = -1; nfire = 0; vld_t = -1; got = 12'd0;
    resp_loc = 12'h312; enable = 1'b1;
    for (int t = 0; t < 2 * P + 10; t++) begin
      tick();
      if (calculate) begin
        nfire++;
        if (fire0 < 0) fire0 = t;
        else if (fire1 < 0) fire1 = t;
      end
      if (location_valid && vld_t < 0) begin
        vld_t = t;
        got = location;
      end
      location_ack = location_valid;
    end
    location_ack = 1'b0;
    compared++; if (fire0 !== 0) begin mismatched++; $display("FAIL periodic_first_fire: got %0d want 0", fire0); end
    compared++; if (fire1 - fire0 !== P) begin mismatched++; $display("FAIL periodic_interval: got %0d want %0d", fire1 - fire0, P); end
    compared++; if (nfire !== 3) begin mismatched++; $display("FAIL periodic_count: got %0d want 3", nfire); end
    compared++; if (vld_t - fire0 !== 8) begin mismatched++; $display("FAIL periodic_latency: got %0d want 8", vld_t - fire0); end
    compared++; if (got !== 12'h312) begin mismatched++; $display("FAIL periodic_location: got %h want 312", got); end
    enable = 1'b0;
    wait_state(ST_IDLE, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL periodic_stop: got state %0d want 0", state); end
  endtask

  task automatic test_median();
    logic [11:0] got;
    bit ok;
    do_reset();
    shot(12'h340, got, ok); ack();
    compared++; if ({ok, got} !== {1'b1, 12'h340}) begin mismatched++; $display("FAIL median_1: got %b/%h want 1/340", ok, got); end
    shot(12'h510, got, ok); ack();
    compared++; if ({ok, got} !== {1'b1, 12'h510}) begin mismatched++; $display("FAIL median_2: got %b/%h want 1/510", ok, got); end
    shot(12'h720, got, ok);
    compared++; if ({ok, got} !== {1'b1, 12'h720}) begin mismatched++; $display("FAIL median_3: got %b/%h want 1/720", ok, got); end
    compared++; if ({state, location_valid} !== {ST_IDLE, 1'b1}) begin mismatched++; $display("FAIL median_idle: got %0d/%b want 0/1", state, location_valid); end
    ack();
    compared++; if (location_valid !== 1'b0) begin mismatched++; $display("FAIL median_ack: got %b want 0", location_valid); end
  endtask

  task automatic test_timeout();
    int first, cnt;
    do_reset();
    resp_en = 1'b0; first = -1; cnt = 0;
    request = 1'b1; tick(); request = 1'b0;
    for (int i = 1; i < T + R + 10; i++) begin
      tick();
      if (calc_reset) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    compared++; if (first !== T + 1) begin mismatched++; $display("FAIL timeout_start: got %0d want %0d", first, T + 1); end
    compared++; if (cnt !== R) begin mismatched++; $display("FAIL timeout_recover_len: got %0d want %0d", cnt, R); end
    compared++; if (fault_count !== 8'd1) begin mismatched++; $display("FAIL timeout_faults: got %0d want 1", fault_count); end
    compared++; if ({location_valid, state} !== {1'b0, ST_IDLE}) begin mismatched++; $display("FAIL timeout_end: got %b/%0d want 0/0", location_valid, state); end
    resp_en = 1'b1;
  endtask

  task automatic test_zero_distance();
    logic [11:0] got;
    bit ok;
    do_reset();
    shot(12'h150, got, ok); ack();
    shot(12'h220, got, ok); ack();
    compared++; if ({ok, got} !== {1'b1, 12'h220}) begin mismatched++; $display("FAIL zero_pre: got %b/%h want 1/220", ok, got); end
    resp_loc = 12'h900; request = 1'b1; tick(); request = 1'b0;
    wait_state(ST_FILTER, ok);
    tick();
    compared++; if ({ok, state} !== {1'b1, ST_IDLE}) begin mismatched++; $display("FAIL zero_skip: got %b/%0d want 1/0", ok, state); end
    repeat (5) tick();
    compared++; if (location_valid !== 1'b0) begin mismatched++; $display("FAIL zero_nopublish: got %b want 0", location_valid); end
    shot(12'hA30, got, ok); ack();
    compared++; if ({ok, got} !== {1'b1, 12'hA30}) begin mismatched++; $display("FAIL zero_history: got %b/%h want 1/a30", ok, got); end
  endtask

  task automatic test_overrun();
    logic [11:0] got;
    bit ok;
    do_reset();
    shot(12'h130, got, ok);
    compared++; if ({location_valid, overrun} !== 2'b10) begin mismatched++; $display("FAIL overrun_first: got %b want 10", {location_valid, overrun}); end
    shot(12'h220, got, ok);
    compared++; if ({ok, got, overrun} !== {1'b1, 12'h220, 1'b1}) begin mismatched++; $display("FAIL overrun_second: got %b/%h/%b want 1/220/1", ok, got, overrun); end
    ack();
    compared++; if ({location_valid, overrun} !== 2'b00) begin mismatched++; $display("FAIL overrun_clear: got %b want 00", {location_valid, overrun}); end
    shot(12'h310, got, ok);
    compared++; if ({ok, got, overrun} !== {1'b1, 12'h320, 1'b0}) begin mismatched++; $display("FAIL overrun_third: got %b/%h/%b want 1/320/0", ok, got, overrun); end
    resp_loc = 12'h405; request = 1'b1; tick(); request = 1'b0;
    wait_state(ST_PUBLISH, ok);
    location_ack = 1'b1; tick(); location_ack = 1'b0;
    compared++; if ({ok, location, location_valid, overrun} !== {1'b1, 12'h410, 1'b1, 1'b0}) begin mismatched++; $display("FAIL overrun_simul_ack: got %b/%h/%b/%b want 1/410/1/0", ok, location, location_valid, overrun); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    resp_loc = 12'h5AA; request = 1'b1; tick(); request = 1'b0;
    wait_state(ST_WAIT_DONE, ok);
    request = 1'b1; tick(); request = 1'b0;
    wait_state(ST_PUBLISH, ok);
    tick();
    compared++; if ({ok, state, calculate} !== {1'b1, ST_FIRE, 1'b1}) begin mismatched++; $display("FAIL b2b_refire: got %b/%0d/%b want 1/2/1", ok, state, calculate); end
    compared++; if ({location, location_valid} !== {12'h5AA, 1'b1}) begin mismatched++; $display("FAIL b2b_first: got %h/%b want 5aa/1", location, location_valid); end
    resp_loc = 12'h6CC;
    wait_state(ST_PUBLISH, ok);
    tick();
    compared++; if ({ok, state, location, overrun} !== {1'b1, ST_IDLE, 12'h6AA, 1'b1}) begin mismatched++; $display("FAIL b2b_second: got %b/%0d/%h/%b want 1/0/6aa/1", ok, state, location, overrun); end
    request = 1'b1; tick(); request = 1'b0;
    wait_state(ST_WAIT_DONE, ok);
    reset_n = 1'b0; tick();
    compared++; if ({state, busy, calculate, location_valid, overrun, location} !== {ST_IDLE, 4'b0, 12'h0}) begin mismatched++; $display("FAIL b2b_midreset: got %0d/%b/%b/%b/%b/%h want 0/0/0/0/0/000", state, busy, calculate, location_valid, overrun, location); end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; request = 1'b0; location_ack = 1'b0;
    resp_en = 1'b1; resp_delay = 5; resp_loc = 12'd0;
    test_reset();
    test_periodic();
    test_median();
    test_timeout();
    test_zero_distance();
    test_overrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
